// File: rtl/arp_reply_transmitter.sv
// ARP reply transmitter: turns qualified ARP requests into 60-byte ARP replies
// streamed as eight 64-bit AXI-Stream beats. One request can wait in a pending
// slot while a reply is in flight; requests arriving with the slot full are dropped.
module arp_reply_transmitter #(
    parameter logic [47:0] FPGA_MAC = 48'h211abcdef112,
    parameter logic [31:0] FPGA_IP  = 32'hC0000186
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [335:0] i_data_head,
    input  logic         i_data_head_valid,
    input  logic         i_arp_valid,
    output logic         o_tx_axis_tvalid,
    output logic [63:0]  o_tx_axis_tdata,
    output logic [7:0]   o_tx_axis_tkeep,
    output logic         o_tx_axis_tlast,
    input  logic         i_tx_axis_tready,
    output logic         o_busy,
    output logic [15:0]  o_drop_count
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e       state_q, state_d;
    logic [2:0]   beat_q, beat_d;
    logic [47:0]  act_sha_q, act_sha_d;
    logic [31:0]  act_spa_q, act_spa_d;
    logic         pend_valid_q, pend_valid_d;
    logic [47:0]  pend_sha_q, pend_sha_d;
    logic [31:0]  pend_spa_q, pend_spa_d;
    logic [15:0]  drop_count_q, drop_count_d;

    logic         req;
    logic [47:0]  req_sha;
    logic [31:0]  req_spa;
    logic         hs;
    logic         last_hs;
    logic [511:0] frame;

    // Frame byte k sits at i_data_head[(42-k)*8-1 -: 8]; SHA is bytes 22..27, SPA 28..31.
    assign req     = i_data_head_valid && i_arp_valid;
    assign req_sha = i_data_head[159:112];
    assign req_spa = i_data_head[111:80];

    assign hs      = (state_q == StSend) && i_tx_axis_tready;
    assign last_hs = hs && (beat_q == 3'd7);

    // Next-state: beat sequencing, pending-slot management and drop counting.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        act_sha_d    = act_sha_q;
        act_spa_d    = act_spa_q;
        pend_valid_d = pend_valid_q;
        pend_sha_d   = pend_sha_q;
        pend_spa_d   = pend_spa_q;
        drop_count_d = drop_count_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d   = StSend;
                    beat_d    = 3'd0;
                    act_sha_d = req_sha;
                    act_spa_d = req_spa;
                end
            end
            StSend: begin
                if (last_hs) begin
                    beat_d = 3'd0;
                    if (pend_valid_q) begin
                        // Pending becomes active; a same-cycle request refills the slot.
                        act_sha_d = pend_sha_q;
                        act_spa_d = pend_spa_q;
                        if (req) begin
                            pend_sha_d = req_sha;
                            pend_spa_d = req_spa;
                        end else begin
                            pend_valid_d = 1'b0;
                        end
                    end else if (req) begin
                        // Same-cycle request goes straight to active, back-to-back.
                        act_sha_d = req_sha;
                        act_spa_d = req_spa;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (hs) begin
                        beat_d = beat_q + 3'd1;
                    end
                    if (req) begin
                        if (!pend_valid_q) begin
                            pend_valid_d = 1'b1;
                            pend_sha_d   = req_sha;
                            pend_spa_d   = req_spa;
                        end else if (drop_count_q != 16'hFFFF) begin
                            drop_count_d = drop_count_q + 16'd1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= StIdle;
            beat_q       <= 3'd0;
            act_sha_q    <= 48'd0;
            act_spa_q    <= 32'd0;
            pend_valid_q <= 1'b0;
            pend_sha_q   <= 48'd0;
            pend_spa_q   <= 32'd0;
            drop_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            act_sha_q    <= act_sha_d;
            act_spa_q    <= act_spa_d;
            pend_valid_q <= pend_valid_d;
            pend_sha_q   <= pend_sha_d;
            pend_spa_q   <= pend_spa_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Reply frame image: byte k at frame[8k +: 8]; bytes 42..63 stay zero (padding).
    always_comb begin
        frame = '0;
        for (int i = 0; i < 6; i++) begin
            frame[8*i +: 8]        = act_sha_q[47-8*i -: 8];
            frame[8*(6+i) +: 8]    = FPGA_MAC[47-8*i -: 8];
            frame[8*(22+i) +: 8]   = FPGA_MAC[47-8*i -: 8];
            frame[8*(32+i) +: 8]   = act_sha_q[47-8*i -: 8];
        end
        // Bytes 12..21: ethertype ARP, HTYPE 1, PTYPE IPv4, HLEN 6, PLEN 4, OPER reply.
        frame[96 +: 80] = {8'h02, 8'h00, 8'h04, 8'h06, 8'h00,
                           8'h08, 8'h01, 8'h00, 8'h06, 8'h08};
        for (int i = 0; i < 4; i++) begin
            frame[8*(28+i) +: 8] = FPGA_IP[31-8*i -: 8];
            frame[8*(38+i) +: 8] = act_spa_q[31-8*i -: 8];
        end
    end

    // AXI-Stream outputs are driven from registered state only; zero while idle.
    always_comb begin
        o_tx_axis_tvalid = 1'b0;
        o_tx_axis_tdata  = 64'd0;
        o_tx_axis_tkeep  = 8'h00;
        o_tx_axis_tlast  = 1'b0;
        if (state_q == StSend) begin
            o_tx_axis_tvalid = 1'b1;
            o_tx_axis_tdata  = frame[{beat_q, 6'd0} +: 64];
            o_tx_axis_tkeep  = (beat_q == 3'd7) ? 8'h0F : 8'hFF;
            o_tx_axis_tlast  = (beat_q == 3'd7);
        end
    end

    assign o_busy       = (state_q == StSend) || pend_valid_q;
    assign o_drop_count = drop_count_q;

endmodule

// File: tb/tb_arp_reply_transmitter.sv
// Self-checking bench for arp_reply_transmitter.
module tb_arp_reply_transmitter;

    localparam logic [47:0] MAC = 48'h211abcdef112;
    localparam logic [31:0] IP  = 32'hC0000186;

    logic         clk = 1'b0;
    logic         i_reset;
    logic [335:0] i_data_head;
    logic         i_data_head_valid;
    logic         i_arp_valid;
    logic         tvalid;
    logic [63:0]  tdata;
    logic [7:0]   tkeep;
    logic         tlast;
    logic         tready;
    logic         busy;
    logic [15:0]  drop_count;

    always #5 clk = ~clk;

    arp_reply_transmitter #(.FPGA_MAC(MAC), .FPGA_IP(IP)) dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_data_head       (i_data_head),
        .i_data_head_valid (i_data_head_valid),
        .i_arp_valid       (i_arp_valid),
        .o_tx_axis_tvalid  (tvalid),
        .o_tx_axis_tdata   (tdata),
        .o_tx_axis_tkeep   (tkeep),
        .o_tx_axis_tlast   (tlast),
        .i_tx_axis_tready  (tready),
        .o_busy            (busy),
        .o_drop_count      (drop_count)
    );

    typedef struct {
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic        tlast;
    } vec_t;

    typedef struct {
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic        tlast;
        int          cyc;
    } beat_t;

    beat_t       q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic        stall_prev = 1'b0;
    logic [63:0] data_prev;
    logic [7:0]  keep_prev;
    logic        last_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor on the falling edge: records handshakes, checks stability under stall.
    always @(negedge clk) begin
        cyc++;
        if (stall_prev && tvalid) begin
            chk("stall_data", tdata, data_prev);
            chk("stall_keep", {56'd0, tkeep}, {56'd0, keep_prev});
            chk("stall_last", {63'd0, tlast}, {63'd0, last_prev});
        end
        if (tvalid && tready) begin
            q.push_back('{tdata: tdata, tkeep: tkeep, tlast: tlast, cyc: cyc});
        end
        stall_prev = tvalid && !tready && !i_reset;
        data_prev  = tdata;
        keep_prev  = tkeep;
        last_prev  = tlast;
    end

    function automatic logic [335:0] mk_head(input logic [47:0] sha, input logic [31:0] spa);
        logic [335:0] h;
        h = {42{8'hA5}};
        h[(42-22)*8-1 -: 48] = sha;
        h[(42-28)*8-1 -: 32] = spa;
        return h;
    endfunction

    // Expected beat b of the reply built from a 480-bit big-endian frame image.
    function automatic logic [63:0] model_beat(input logic [47:0] sha, input logic [31:0] spa,
                                               input int b);
        logic [479:0] f;
        logic [63:0]  d;
        int           k;
        f = {sha, MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
             MAC, IP, sha, spa, 144'd0};
        d = '0;
        for (int n = 0; n < 8; n++) begin
            k = b * 8 + n;
            if (k < 60) d[8*n +: 8] = f[479-8*k -: 8];
        end
        return d;
    endfunction

    // Called just after a rising edge; the request is sampled at the next edge.
    task automatic pulse(input logic [47:0] sha, input logic [31:0] spa,
                         input logic hv, input logic arp);
        i_data_head       = mk_head(sha, spa);
        i_data_head_valid = hv;
        i_arp_valid       = arp;
        @(posedge clk); #1;
        i_data_head_valid = 1'b0;
        i_arp_valid       = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        i_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        q.delete();
    endtask

    task automatic wait_beats(input string name, input int n, input int budget);
        int c;
        c = 0;
        while (q.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        n_cmp++;
        if (q.size() < n) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d beats, want %0d", name, q.size(), n);
        end
    endtask

    task automatic check_frame(input string name, input int base, input logic [47:0] sha,
                               input logic [31:0] spa, input bit chain);
        beat_t r;
        for (int b = 0; b < 8; b++) begin
            if (base + b >= q.size()) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s_b%0d_missing: got %0d beats, want %0d", name, b, q.size(),
                         base + b + 1);
                continue;
            end
            r = q[base+b];
            chk($sformatf("%s_b%0d_data", name, b), r.tdata, model_beat(sha, spa, b));
            chk($sformatf("%s_b%0d_keep", name, b), {56'd0, r.tkeep},
                (b == 7) ? 64'h0F : 64'hFF);
            chk($sformatf("%s_b%0d_last", name, b), {63'd0, r.tlast}, (b == 7) ? 64'd1 : 64'd0);
            if ((b > 0 || chain) && base + b > 0) begin
                chk($sformatf("%s_b%0d_gap", name, b), r.cyc, q[base+b-1].cyc + 1);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    localparam logic [47:0] SHA_A = 48'h0A0B0C0D0E0F;
    localparam logic [31:0] SPA_A = 32'hC0000101;
    localparam logic [47:0] SHA_B = 48'h123456789ABC;
    localparam logic [31:0] SPA_B = 32'h0A000002;
    localparam logic [47:0] SHA_C = 48'hFEDCBA987654;
    localparam logic [31:0] SPA_C = 32'hAC100005;

    initial begin
        vec_t       exp1[8];
        logic [3:0] pat;

        exp1[0] = '{64'h1a210F0E0D0C0B0A, 8'hFF, 1'b0};
        exp1[1] = '{64'h0100060812f1debc, 8'hFF, 1'b0};
        exp1[2] = '{64'h1a21020004060008, 8'hFF, 1'b0};
        exp1[3] = '{64'h860100C012f1debc, 8'hFF, 1'b0};
        exp1[4] = '{64'h00C00F0E0D0C0B0A, 8'hFF, 1'b0};
        exp1[5] = '{64'h0000000000000101, 8'hFF, 1'b0};
        exp1[6] = '{64'h0000000000000000, 8'hFF, 1'b0};
        exp1[7] = '{64'h0000000000000000, 8'h0F, 1'b1};

        i_reset           = 1'b1;
        i_data_head       = '0;
        i_data_head_valid = 1'b0;
        i_arp_valid       = 1'b0;
        tready            = 1'b1;
        do_reset();

        // Reset state.
        chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_tkeep", {56'd0, tkeep}, 64'd0);
        chk("rst_tlast", {63'd0, tlast}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_drop", {48'd0, drop_count}, 64'd0);

        // 1: basic reply, latency 1, table-driven beat comparison.
        i_data_head       = mk_head(SHA_A, SPA_A);
        i_data_head_valid = 1'b1;
        i_arp_valid       = 1'b1;
        @(negedge clk);
        chk("t1_lat_pre", {63'd0, tvalid}, 64'd0);
        @(posedge clk); #1;
        i_data_head_valid = 1'b0;
        i_arp_valid       = 1'b0;
        @(negedge clk);
        chk("t1_lat_post", {63'd0, tvalid}, 64'd1);
        wait_beats("t1", 8, 40);
        for (int b = 0; b < 8 && b < q.size(); b++) begin
            chk($sformatf("t1_b%0d_data", b), q[b].tdata, exp1[b].tdata);
            chk($sformatf("t1_b%0d_keep", b), {56'd0, q[b].tkeep}, {56'd0, exp1[b].tkeep});
            chk($sformatf("t1_b%0d_last", b), {63'd0, q[b].tlast}, {63'd0, exp1[b].tlast});
            if (b > 0) chk($sformatf("t1_b%0d_gap", b), q[b].cyc, q[b-1].cyc + 1);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("t1_count", q.size(), 8);
        chk("t1_busy_after", {63'd0, busy}, 64'd0);

        // 2: backpressure with tready pattern 1,0,0,1.
        q.delete();
        pat = 4'b1001;
        @(posedge clk); #1;
        pulse(SHA_A, SPA_A, 1'b1, 1'b1);
        for (int c = 0; c < 60 && q.size() < 8; c++) begin
            tready = pat[c % 4];
            @(posedge clk); #1;
        end
        tready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t2_count", q.size(), 8);
        for (int b = 0; b < 8 && b < q.size(); b++) begin
            chk($sformatf("t2_b%0d_data", b), q[b].tdata, exp1[b].tdata);
            chk($sformatf("t2_b%0d_last", b), {63'd0, q[b].tlast}, {63'd0, exp1[b].tlast});
        end

        // 3: A, B, C in consecutive cycles -> A, B back-to-back, C dropped.
        q.delete();
        @(posedge clk); #1;
        pulse(SHA_A, SPA_A, 1'b1, 1'b1);
        pulse(SHA_B, SPA_B, 1'b1, 1'b1);
        pulse(SHA_C, SPA_C, 1'b1, 1'b1);
        chk("t3_busy_mid", {63'd0, busy}, 64'd1);
        wait_beats("t3", 16, 60);
        check_frame("t3_A", 0, SHA_A, SPA_A, 1'b0);
        check_frame("t3_B", 8, SHA_B, SPA_B, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("t3_count", q.size(), 16);
        chk("t3_drop", {48'd0, drop_count}, 64'd1);
        chk("t3_busy_after", {63'd0, busy}, 64'd0);

        // 5: filtering; drop count must stay at 1.
        q.delete();
        @(posedge clk); #1;
        pulse(SHA_B, SPA_B, 1'b1, 1'b0);
        pulse(SHA_B, SPA_B, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_count", q.size(), 0);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_drop", {48'd0, drop_count}, 64'd1);

        // 4: pending B, C arrives with A's last-beat handshake -> A, B, C, no drop.
        do_reset();
        pulse(SHA_A, SPA_A, 1'b1, 1'b1);
        pulse(SHA_B, SPA_B, 1'b1, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        pulse(SHA_C, SPA_C, 1'b1, 1'b1);
        wait_beats("t4", 24, 80);
        check_frame("t4_A", 0, SHA_A, SPA_A, 1'b0);
        check_frame("t4_B", 8, SHA_B, SPA_B, 1'b1);
        check_frame("t4_C", 16, SHA_C, SPA_C, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_count", q.size(), 24);
        chk("t4_drop", {48'd0, drop_count}, 64'd0);

        // 4b: pending empty, request on last-beat handshake -> direct back-to-back.
        q.delete();
        pulse(SHA_B, SPA_B, 1'b1, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        pulse(SHA_C, SPA_C, 1'b1, 1'b1);
        wait_beats("t4b", 16, 60);
        check_frame("t4b_B", 0, SHA_B, SPA_B, 1'b0);
        check_frame("t4b_C", 8, SHA_C, SPA_C, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("t4b_count", q.size(), 16);
        chk("t4b_drop", {48'd0, drop_count}, 64'd0);

        // 6: reset at beat 3 with B pending and one drop counted.
        q.delete();
        pulse(SHA_A, SPA_A, 1'b1, 1'b1);
        pulse(SHA_B, SPA_B, 1'b1, 1'b1);
        pulse(SHA_C, SPA_C, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("t6_drop_pre", {48'd0, drop_count}, 64'd1);
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        chk("t6_tvalid", {63'd0, tvalid}, 64'd0);
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_drop", {48'd0, drop_count}, 64'd0);
        chk("t6_partial", q.size(), 4);
        for (int b = 0; b < q.size(); b++) begin
            chk($sformatf("t6_p%0d_last", b), {63'd0, q[b].tlast}, 64'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t6_idle_count", q.size(), 4);
        q.delete();
        pulse(SHA_C, SPA_C, 1'b1, 1'b1);
        wait_beats("t6", 8, 40);
        check_frame("t6_new", 0, SHA_C, SPA_C, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t6_count", q.size(), 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/arp_reply_transmitter.md
Name: arp_reply_transmitter

Overview:
- Downstream consumer of the Ethernet header receiver stage.
- Takes each qualified ARP request (the 42-byte parsed header plus the ARP-valid flag) and builds the matching 60-byte ARP reply, zero-padded, FCS left to the MAC.
- Streams the reply on a 64-bit AXI-Stream TX interface toward the 10G MAC.
- Holds one pending request while a reply is in flight; counts requests it has to drop.

Parameters:
FPGA_MAC, 48'h211abcdef112, local MAC; used as reply source MAC and as SHA.
FPGA_IP, 32'hC0000186, local IPv4 address; used as SPA.

Ports:
i_clk  input  1  single clock.
i_reset  input  1  synchronous, active-high reset.
i_data_head  input  336  parsed header. Frame byte k is at [(42-k)*8-1 -: 8], so byte 0 is the MSB byte.
i_data_head_valid  input  1  one-cycle strobe; i_data_head is valid this cycle.
i_arp_valid  input  1  header is an ARP request addressed to us.
o_tx_axis_tvalid  output  1  AXIS valid.
o_tx_axis_tdata  output  64  frame byte n of a beat is on [8n+7:8n].
o_tx_axis_tkeep  output  8  byte enables.
o_tx_axis_tlast  output  1  last beat of the frame.
i_tx_axis_tready  input  1  AXIS ready.
o_busy  output  1  high while a frame is in flight or a request is pending.
o_drop_count  output  16  saturating count of dropped requests.

Behaviour:
- Clock and reset: single clock i_clk; reset i_reset is synchronous and active-high. Everything samples on posedge i_clk.
- Reset values: all outputs 0, state IDLE, pending slot empty, beat counter 0.
- Request capture: a request is i_data_head_valid && i_arp_valid.
  - Capture only SHA = bytes 22..27 and SPA = bytes 28..31.
  - No other fields are stored.
- Reply frame, bytes 0..59:
  - Bytes 0..5: DST = captured SHA.
  - Bytes 6..11: SRC = FPGA_MAC.
  - Bytes 12..21: 08 06, 00 01, 08 00, 06, 04, 00 02.
  - Bytes 22..27: SHA = FPGA_MAC.
  - Bytes 28..31: SPA = FPGA_IP.
  - Bytes 32..37: THA = captured SHA.
  - Bytes 38..41: TPA = captured SPA.
  - Bytes 42..59: 0x00 padding.
- Beat layout: 8 beats, index 0..7.
  - Beats 0..6: tkeep 8'hFF.
  - Beat 7: tkeep 8'h0F, tlast 1; tdata[63:32] = 0.
- State machine:
  - IDLE: on a request, load the active registers; go to SEND with beat 0. tvalid rises the cycle after the request (latency 1).
  - SEND: tvalid held high. tdata, tkeep and tlast stay stable until tvalid && tready.
  - SEND, on handshake with beat < 7: beat increments.
  - SEND, on handshake with beat 7 and pending full: load pending into active and present beat 0 the next cycle. tvalid stays high, with no idle gap.
  - SEND, on handshake with beat 7 and pending empty: go to IDLE; tvalid drops the next cycle.
- Request while not IDLE:
  - Pending empty: store in pending.
  - Pending full and not being consumed this cycle: drop the request and increment o_drop_count, saturating at 16'hFFFF.
  - Same cycle as the last-beat handshake with pending full: pending moves to active and the new request takes pending. No drop.
  - Same cycle as the last-beat handshake with pending empty: the new request becomes the next active frame directly (back-to-back). No drop.
- Requests with i_arp_valid=0, or with i_data_head_valid=0, are ignored; o_drop_count is unchanged.
- o_busy = (state==SEND) || pending full.
- Reset mid-frame: the frame is abandoned with no tlast; pending and o_drop_count are cleared; tvalid is 0 the cycle after reset is sampled.

Test Plan:
1. Basic reply, FPGA defaults. Request with SHA=0A0B0C0D0E0F, SPA=C0000101, tready=1 throughout. Required beats:
   - Beat 0: tdata=64'h1a210F0E0D0C0B0A.
   - Beat 1: 64'h0100060812f1debc.
   - Beat 2: 64'h1a21020004060008.
   - Beat 3: 64'h860100C012f1debc.
   - Beat 4: 64'h00C00F0E0D0C0B0A.
   - Beat 5: 64'h0000000000000101.
   - Beat 6: 0.
   - Beat 7: tdata 0, tkeep 8'h0F, tlast 1.
   - tvalid first high one cycle after the strobe; exactly 8 consecutive beats.
2. Backpressure: same request, tready toggling 1,0,0,1,... -> identical byte sequence; tdata, tkeep and tlast never change while tvalid=1 and tready=0; still 8 beats total.
3. Pending plus drop: requests A, B, C issued in consecutive cycles with tready=1 -> frame A then frame B back-to-back with no tvalid gap; C dropped; o_drop_count=1; o_busy low after B's tlast.
4. Simultaneous events: pending holds B; request C arrives in the same cycle as A's beat-7 handshake -> frames A, B, C are sent in order and o_drop_count stays 0.
5. Filtering: i_data_head_valid=1 with i_arp_valid=0 -> no tvalid; o_drop_count unchanged.
6. Reset mid-frame: assert i_reset at beat 3 while a request is pending -> the next cycle tvalid=0, o_busy=0 and o_drop_count=0; a new request afterwards produces a clean 8-beat frame.
